// File: rtl/stack_mips_core.sv
// Multi-cycle 8-bit stack processor: control FSM, 32-byte unified memory, 16-entry stack.
// ALU ops take 5-6 cycles, PUSH takes 4, POP/JMP/JZ take 3. load_en idles the core and writes memory.
module stack_mips_core #(
  parameter int STACK_DEPTH = 16,
  parameter int MEM_WORDS   = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load_en,
  input  logic [$clog2(MEM_WORDS)-1:0]           load_addr,
  input  logic [7:0]                             load_data,
  output logic [$clog2(MEM_WORDS)-1:0]           pc,
  output logic [7:0]                             ir,
  output logic [7:0]                             tos_data,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       depth
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int SW = $clog2(STACK_DEPTH);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_POPA, S_POPB, S_EXEC, S_PUSHR,
    S_MEMRD, S_PUSHM, S_WR, S_JMPS, S_BR
  } state_e;

  logic [7:0]    mem_q [MEM_WORDS];
  logic [7:0]    stk_q [STACK_DEPTH];
  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [7:0]    ir_q, a_q, b_q, alu_q, mdr_q;
  logic [DW-1:0] depth_q, depth_d;
  logic [7:0]    alu_d, tos, push_val;
  logic [SW-1:0] top_idx;
  logic          empty, full, push_en, pop_en;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DW'(STACK_DEPTH));
  assign top_idx  = SW'(depth_q - 1'b1);
  // An empty stack reads as zero for pops, JZ and the tos port alike.
  assign tos      = empty ? 8'h00 : stk_q[top_idx];
  assign push_en  = !load_en && (state_q == S_PUSHR || state_q == S_PUSHM);
  assign pop_en   = !load_en && (state_q == S_POPA || state_q == S_POPB || state_q == S_WR);
  assign push_val = (state_q == S_PUSHR) ? alu_q : mdr_q;

  always_comb begin
    depth_d = depth_q;
    if (push_en && !full)
      depth_d = depth_q + 1'b1;
    else if (pop_en && !empty)
      depth_d = depth_q - 1'b1;
  end

  always_comb begin
    alu_d = 8'h00;
    case (ir_q[6:5])
      2'b00:   alu_d = b_q + a_q;
      2'b01:   alu_d = b_q - a_q;
      2'b10:   alu_d = b_q & a_q;
      default: alu_d = ~a_q;
    endcase
  end

  // Memory and stack contents survive reset; only depth is cleared.
  always_ff @(posedge clk) begin
    if (load_en)
      mem_q[load_addr] <= load_data;
    else if (state_q == S_WR)
      mem_q[ir_q[AW-1:0]] <= tos;
  end

  always_ff @(posedge clk) begin
    if (push_en && !full)
      stk_q[SW'(depth_q)] <= push_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      depth_q <= '0;
    end else if (load_en) begin
      state_q <= S_IF;
    end else begin
      depth_q <= depth_d;
      case (state_q)
        S_IF: begin
          ir_q    <= mem_q[pc_q];
          pc_q    <= pc_q + 1'b1;
          state_q <= S_ID;
        end
        S_ID: begin
          case (ir_q[7:5])
            3'b000, 3'b001, 3'b010, 3'b011: state_q <= S_POPA;
            3'b100:  state_q <= S_MEMRD;
            3'b101:  state_q <= S_WR;
            3'b110:  state_q <= S_JMPS;
            default: state_q <= S_BR;
          endcase
        end
        S_POPA: begin
          a_q     <= tos;
          state_q <= (ir_q[7:5] == 3'b011) ? S_EXEC : S_POPB;
        end
        S_POPB: begin
          b_q     <= tos;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          alu_q   <= alu_d;
          state_q <= S_PUSHR;
        end
        S_MEMRD: begin
          mdr_q   <= mem_q[ir_q[AW-1:0]];
          state_q <= S_PUSHM;
        end
        S_JMPS: begin
          pc_q    <= ir_q[AW-1:0];
          state_q <= S_IF;
        end
        S_BR: begin
          if (tos == 8'h00)
            pc_q <= ir_q[AW-1:0];
          state_q <= S_IF;
        end
        default: state_q <= S_IF;
      endcase
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign tos_data = tos;
  assign depth    = depth_q;
endmodule

// File: tb/tb_stack_mips_core.sv
// Randomised and directed bench for stack_mips_core with an instruction-level reference model.
module tb_stack_mips_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic [4:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [4:0] pc, depth;
  logic [7:0] ir, tos_data;

  stack_mips_core dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .pc(pc), .ir(ir), .tos_data(tos_data), .depth(depth)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         stamp;
    int         id;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [7:0] tos;
    logic [4:0] depth;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   nid = 0;
  int   tstamp = 0;

  // Architectural model: plain memory array, stack as a queue, pc as an integer.
  logic [7:0] mmem [32];
  logic [7:0] mstk [$];
  int         mpc = 0;
  logic [7:0] mir = 8'h00;
  logic [4:0] ld_a [$];
  logic [7:0] ld_d [$];

  function automatic logic [7:0] mtop();
    if (mstk.size() == 0) return 8'h00;
    return mstk[$];
  endfunction

  function automatic logic [7:0] mpop();
    if (mstk.size() == 0) return 8'h00;
    return mstk.pop_back();
  endfunction

  function automatic void mpush(logic [7:0] v);
    if (mstk.size() < 16) mstk.push_back(v);
  endfunction

  task automatic model_reset();
    mstk.delete();
    mpc = 0;
    mir = 8'h00;
  endtask

  task automatic model_step(output int c);
    logic [7:0] ins, a, b, r;
    logic [2:0] op;
    logic [4:0] ad;
    ins = mmem[mpc];
    op  = ins[7:5];
    ad  = ins[4:0];
    mir = ins;
    mpc = (mpc + 1) % 32;
    c   = 3;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        a = mpop();
        b = mpop();
        if (op == 3'd0)      r = b + a;
        else if (op == 3'd1) r = b - a;
        else                 r = b & a;
        mpush(r);
        c = 6;
      end
      3'd3: begin a = mpop(); mpush(~a); c = 5; end
      3'd4: begin mpush(mmem[ad]); c = 4; end
      3'd5: begin mmem[ad] = mpop(); c = 3; end
      3'd6: begin mpc = int'(ad); c = 3; end
      default: begin if (mtop() == 8'h00) mpc = int'(ad); c = 3; end
    endcase
  endtask

  task automatic push_exp(input int stamp);
    exp_t e;
    e.stamp = stamp;
    e.id    = nid;
    e.pc    = 5'(mpc);
    e.ir    = mir;
    e.tos   = mtop();
    e.depth = 5'(mstk.size());
    nid++;
    exp_q.push_back(e);
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    ld_a.push_back(a);
    ld_d.push_back(d);
  endtask

  // Hold reset while the queued bytes are loaded, then release the core.
  task automatic start_prog();
    @(negedge clk); #1;
    rst = 1'b0;
    load_en = 1'b1;
    model_reset();
    push_exp(cyc + 1);
    while (ld_a.size() > 0) begin
      load_addr = ld_a.pop_front();
      load_data = ld_d.pop_front();
      mmem[load_addr] = load_data;
      @(negedge clk); #1;
    end
    load_en = 1'b0;
    rst = 1'b1;
    tstamp = cyc;
  endtask

  task automatic run_instrs(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      model_step(c);
      tstamp += c;
      push_exp(tstamp);
    end
  endtask

  task automatic settle();
    while (cyc < tstamp) @(negedge clk);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && cyc >= exp_q[0].stamp) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (cyc != mon_e.stamp ||
            {pc, ir, tos_data, depth} !== {mon_e.pc, mon_e.ir, mon_e.tos, mon_e.depth}) begin
          failures++;
          $display("FAIL step%0d cyc=%0d: got pc=%0d ir=%02h tos=%02h depth=%0d, expected pc=%0d ir=%02h tos=%02h depth=%0d",
                   mon_e.id, cyc, pc, ir, tos_data, depth,
                   mon_e.pc, mon_e.ir, mon_e.tos, mon_e.depth);
        end
      end
    end
  end

  initial begin : timeout
    #600000;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int a = 0; a < 32; a++) mmem[a] = 8'h00;

    // ADD program: mem[12] gets 05+07, then JMP 4 loops.
    for (int a = 0; a < 32; a++) poke(5'(a), 8'h00);
    poke(5'd0, 8'h8A); poke(5'd1, 8'h8B); poke(5'd2, 8'h00);
    poke(5'd3, 8'hAC); poke(5'd4, 8'hC4);
    poke(5'd10, 8'h05); poke(5'd11, 8'h07);
    start_prog();
    run_instrs(7);
    settle();

    // Read back mem[12] without reloading it.
    poke(5'd0, 8'h8C); poke(5'd1, 8'hC1);
    start_prog();
    run_instrs(3);
    settle();

    // SUB ordering both ways.
    poke(5'd10, 8'h09); poke(5'd11, 8'h03);
    poke(5'd0, 8'h8A); poke(5'd1, 8'h8B); poke(5'd2, 8'h20); poke(5'd3, 8'hC3);
    start_prog();
    run_instrs(5);
    settle();
    poke(5'd0, 8'h8B); poke(5'd1, 8'h8A);
    start_prog();
    run_instrs(5);
    settle();

    // NOT then AND.
    poke(5'd20, 8'h0F); poke(5'd21, 8'h3C);
    poke(5'd0, 8'h94); poke(5'd1, 8'h60); poke(5'd2, 8'h95);
    poke(5'd3, 8'h40); poke(5'd4, 8'hC4);
    start_prog();
    run_instrs(6);
    settle();

    // JZ taken on zero, not taken on nonzero, taken on empty stack.
    poke(5'd22, 8'h00); poke(5'd23, 8'h01);
    poke(5'd0, 8'h96); poke(5'd1, 8'hE7); poke(5'd7, 8'h97); poke(5'd8, 8'hE7);
    poke(5'd9, 8'hAF); poke(5'd10, 8'hAF); poke(5'd11, 8'hEC); poke(5'd12, 8'hCC);
    start_prog();
    run_instrs(9);
    settle();

    // 17 pushes saturate at depth 16.
    for (int i = 0; i < 17; i++) poke(5'(i), 8'h80 | 8'(18 + (i % 14)));
    poke(5'd17, 8'hD1);
    for (int k = 0; k < 14; k++) poke(5'(18 + k), 8'h40 + 8'(k));
    start_prog();
    run_instrs(19);
    settle();

    // POP on empty stack writes 00.
    poke(5'd30, 8'h77);
    poke(5'd0, 8'hBE); poke(5'd1, 8'h9E); poke(5'd2, 8'hC2);
    start_prog();
    run_instrs(4);
    settle();

    // Reset asserted while ADD is in its second pop.
    poke(5'd10, 8'h21); poke(5'd11, 8'h34);
    poke(5'd0, 8'h8A); poke(5'd1, 8'h8B); poke(5'd2, 8'h00); poke(5'd3, 8'hC3);
    start_prog();
    run_instrs(2);
    while (cyc < tstamp + 2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    push_exp(cyc);
    tstamp = cyc;
    settle();
    @(negedge clk); #1;
    rst = 1'b1;
    tstamp = cyc;
    run_instrs(5);
    settle();

    // Random memory images, including self-modifying code and stack overflow/underflow.
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 32; a++) poke(5'(a), 8'($urandom));
      start_prog();
      run_instrs(40);
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
